// File: rtl/mac_accum_pipe.sv
// mac_accum_pipe: pipelined signed multiply-accumulate stage.
//
// Computes p <= f(p, a*b, c) for each valid sample, where the opcode picks
// ACC (p+m+c), LOAD (m+c), SUB (p-m+c) or CLEAR (0). The sum is formed two
// bits wider than the accumulator so overflow is exact. On overflow it either
// clamps to the nearest bound (SATURATE=1) or wraps (SATURATE=0), and flags ovf.
// Latency is 2+MREG ce-enabled cycles, and throughput is one sample per cycle.
// The parameters must satisfy PWIDTH >= AWIDTH+BWIDTH and PWIDTH >= CWIDTH.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; takes priority over ce
//   ce         clock enable; 0 freezes every register
//   in_valid   sample qualifier
//   mode       2-bit opcode: 00 ACC, 01 LOAD, 10 SUB, 11 CLEAR
//   a, b       signed multiplier operands
//   c          signed addend
//   p          signed accumulator value (registered)
//   out_valid  p was updated by a valid sample on the last enabled edge
//   ovf        the result carried with out_valid overflowed
module mac_accum_pipe #(
  parameter int unsigned AWIDTH   = 16,
  parameter int unsigned BWIDTH   = 16,
  parameter int unsigned CWIDTH   = 32,
  parameter int unsigned PWIDTH   = 40,
  parameter int unsigned MREG     = 1,
  parameter int unsigned SATURATE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic                     in_valid,
  input  logic [1:0]               mode,
  input  logic signed [AWIDTH-1:0] a,
  input  logic signed [BWIDTH-1:0] b,
  input  logic signed [CWIDTH-1:0] c,
  output logic signed [PWIDTH-1:0] p,
  output logic                     out_valid,
  output logic                     ovf
);

  localparam int unsigned MWIDTH = AWIDTH + BWIDTH;
  localparam int unsigned SWIDTH = PWIDTH + 2;

  localparam logic [1:0] ModeAcc   = 2'b00;
  localparam logic [1:0] ModeLoad  = 2'b01;
  localparam logic [1:0] ModeSub   = 2'b10;
  localparam logic [1:0] ModeClear = 2'b11;

  localparam logic signed [PWIDTH-1:0] PMax = {1'b0, {(PWIDTH-1){1'b1}}};
  localparam logic signed [PWIDTH-1:0] PMin = {1'b1, {(PWIDTH-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // S1: input registers. Data loads regardless of in_valid.
  // ---------------------------------------------------------------------------
  logic signed [AWIDTH-1:0] r_a;
  logic signed [BWIDTH-1:0] r_b;
  logic signed [CWIDTH-1:0] r_c;
  logic [1:0]               r_mode;
  logic                     r_v1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= '0;
      r_mode <= '0;
      r_v1   <= 1'b0;
    end else if (ce) begin
      r_a    <= a;
      r_b    <= b;
      r_c    <= c;
      r_mode <= mode;
      r_v1   <= in_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: full-width signed product, optionally registered with its side-band.
  // ---------------------------------------------------------------------------
  logic signed [MWIDTH-1:0] w_prod;
  logic signed [MWIDTH-1:0] w_m;
  logic signed [CWIDTH-1:0] w_c2;
  logic [1:0]               w_mode2;
  logic                     w_v2;

  assign w_prod = MWIDTH'(r_a) * MWIDTH'(r_b);

  if (MREG != 0) begin : g_mreg
    logic signed [MWIDTH-1:0] r_m;
    logic signed [CWIDTH-1:0] r_c2;
    logic [1:0]               r_mode2;
    logic                     r_v2;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_m     <= '0;
        r_c2    <= '0;
        r_mode2 <= '0;
        r_v2    <= 1'b0;
      end else if (ce) begin
        r_m     <= w_prod;
        r_c2    <= r_c;
        r_mode2 <= r_mode;
        r_v2    <= r_v1;
      end
    end

    assign w_m     = r_m;
    assign w_c2    = r_c2;
    assign w_mode2 = r_mode2;
    assign w_v2    = r_v2;
  end else begin : g_no_mreg
    assign w_m     = w_prod;
    assign w_c2    = r_c;
    assign w_mode2 = r_mode;
    assign w_v2    = r_v1;
  end

  // ---------------------------------------------------------------------------
  // S3: accumulate. Two guard bits make the range check exact for every mode.
  // ---------------------------------------------------------------------------
  logic signed [PWIDTH-1:0] r_p;
  logic                     r_out_valid;
  logic                     r_ovf;

  logic signed [SWIDTH-1:0] w_m_ext;
  logic signed [SWIDTH-1:0] w_c_ext;
  logic signed [SWIDTH-1:0] w_p_ext;
  logic signed [SWIDTH-1:0] w_s;
  logic [2:0]               w_top;
  logic                     w_ovf;
  logic signed [PWIDTH-1:0] w_p_next;

  assign w_m_ext = SWIDTH'(w_m);
  assign w_c_ext = SWIDTH'(w_c2);
  assign w_p_ext = SWIDTH'(r_p);

  always_comb begin
    w_s = '0;
    case (w_mode2)
      ModeAcc:   w_s = w_p_ext + w_m_ext + w_c_ext;
      ModeLoad:  w_s = w_m_ext + w_c_ext;
      ModeSub:   w_s = w_p_ext - w_m_ext + w_c_ext;
      ModeClear: w_s = '0;
      default:   w_s = '0;
    endcase
  end

  // In range iff the guard bits and the accumulator sign bit all agree.
  assign w_top = w_s[SWIDTH-1:PWIDTH-1];
  assign w_ovf = (w_top != 3'b000) && (w_top != 3'b111);

  always_comb begin
    w_p_next = w_s[PWIDTH-1:0];
    if ((SATURATE != 0) && w_ovf) begin
      w_p_next = w_s[SWIDTH-1] ? PMin : PMax;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p         <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (ce) begin
      r_out_valid <= w_v2;
      if (w_v2) begin
        r_p   <= w_p_next;
        r_ovf <= w_ovf;
      end
    end
  end

  assign p         = r_p;
  assign out_valid = r_out_valid;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_mac_accum_pipe.sv
// Directed bench for mac_accum_pipe. Two instances share most stimulus:
//   dut_s: defaults (MREG=1, SATURATE=1, CWIDTH=32), latency 3
//   dut_w: MREG=0, SATURATE=0, CWIDTH=40, latency 2, wide addend c_w
module tb_mac_accum_pipe;

  localparam logic [1:0] Acc   = 2'b00;
  localparam logic [1:0] Load  = 2'b01;
  localparam logic [1:0] Sub   = 2'b10;
  localparam logic [1:0] Clear = 2'b11;

  localparam logic signed [63:0] PMax = 64'sd549755813887;   // 2^39-1
  localparam logic signed [63:0] PMin = -64'sd549755813888;  // -2^39
  localparam logic signed [63:0] Samp = 64'sd3221159936;     // 32767^2 + 2^31-1
  localparam int NSat = 175;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               ce;
  logic               in_valid;
  logic [1:0]         mode;
  logic signed [15:0] a;
  logic signed [15:0] b;
  logic signed [31:0] c;
  logic signed [39:0] c_w;

  logic signed [39:0] p_s;
  logic               ov_s;
  logic               ovf_s;
  logic signed [39:0] p_w;
  logic               ov_w;
  logic               ovf_w;

  int n_checks = 0;
  int n_pass   = 0;

  mac_accum_pipe #(
    .AWIDTH(16), .BWIDTH(16), .CWIDTH(32), .PWIDTH(40), .MREG(1), .SATURATE(1)
  ) dut_s (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .mode(mode),
    .a(a), .b(b), .c(c), .p(p_s), .out_valid(ov_s), .ovf(ovf_s)
  );

  mac_accum_pipe #(
    .AWIDTH(16), .BWIDTH(16), .CWIDTH(40), .PWIDTH(40), .MREG(0), .SATURATE(0)
  ) dut_w (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .mode(mode),
    .a(a), .b(b), .c(c_w), .p(p_w), .out_valid(ov_w), .ovf(ovf_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] md, input logic signed [15:0] aa,
                       input logic signed [15:0] bb, input logic signed [31:0] cc);
    in_valid = v;
    mode     = md;
    a        = aa;
    b        = bb;
    c        = cc;
    c_w      = {{8{cc[31]}}, cc};
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_s(input string tag, input logic signed [63:0] ep, input logic ev,
                       input logic eo);
    chk({tag, ".s.p"}, p_s, ep);
    chk({tag, ".s.valid"}, {63'd0, ov_s}, {63'd0, ev});
    chk({tag, ".s.ovf"}, {63'd0, ovf_s}, {63'd0, eo});
  endtask

  task automatic chk_w(input string tag, input logic signed [63:0] ep, input logic ev,
                       input logic eo);
    chk({tag, ".w.p"}, p_w, ep);
    chk({tag, ".w.valid"}, {63'd0, ov_w}, {63'd0, ev});
    chk({tag, ".w.ovf"}, {63'd0, ovf_w}, {63'd0, eo});
  endtask

  initial begin
    longint n;
    logic signed [63:0] e;
    logic eo;

    // 1. Reset with random inputs, then L-1 quiet cycles after release.
    rst = 1'b1;
    ce  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 32'($urandom));
      tick();
      chk_s("reset", 0, 1'b0, 1'b0);
      chk_w("reset", 0, 1'b0, 1'b0);
    end
    rst = 1'b0;
    drive(1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 32'($urandom));
    tick();
    chk_s("post_reset0", 0, 1'b0, 1'b0);
    chk_w("post_reset0", 0, 1'b0, 1'b0);
    drive(1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 32'($urandom));
    tick();
    chk_s("post_reset1", 0, 1'b0, 1'b0);
    drive(1'b0, Acc, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();

    // 2. LOAD/ACC/ACC back to back: 17, 6, 55.
    drive(1'b1, Load, 3, 4, 5);
    tick();
    drive(1'b1, Acc, -2, 6, 1);
    tick();
    chk_w("acc_run1", 17, 1'b1, 1'b0);
    drive(1'b1, Acc, 7, 7, 0);
    tick();
    chk_s("acc_run1", 17, 1'b1, 1'b0);
    chk_w("acc_run2", 6, 1'b1, 1'b0);
    drive(1'b0, Acc, 0, 0, 0);
    tick();
    chk_s("acc_run2", 6, 1'b1, 1'b0);
    chk_w("acc_run3", 55, 1'b1, 1'b0);
    tick();
    chk_s("acc_run3", 55, 1'b1, 1'b0);
    chk_w("acc_idle", 55, 1'b0, 1'b0);
    tick();
    chk_s("acc_idle", 55, 1'b0, 1'b0);

    // 3. Bubble plus a 2-cycle ce stall while samples are in flight.
    drive(1'b1, Load, 1, 1, 0);
    tick();
    drive(1'b0, Acc, 0, 0, 0);
    tick();
    drive(1'b1, Acc, 2, 2, 0);
    tick();
    chk_s("stall_load", 1, 1'b1, 1'b0);
    drive(1'b0, Acc, 0, 0, 0);
    ce = 1'b0;
    tick();
    chk_s("stall_hold0", 1, 1'b1, 1'b0);
    tick();
    chk_s("stall_hold1", 1, 1'b1, 1'b0);
    ce = 1'b1;
    tick();
    chk_s("stall_bubble", 1, 1'b0, 1'b0);
    tick();
    chk_s("stall_acc", 5, 1'b1, 1'b0);
    tick();
    chk_s("stall_drain", 5, 1'b0, 1'b0);

    // 4. Saturation: repeated max-ish sample until the sum crosses 2^39-1.
    for (int j = 0; j < NSat + 2; j++) begin
      if (j == 0) drive(1'b1, Load, 32767, 32767, 32'sd2147483647);
      else if (j < NSat) drive(1'b1, Acc, 32767, 32767, 32'sd2147483647);
      else drive(1'b0, Acc, 0, 0, 0);
      tick();
      if (j >= 2) begin
        n  = longint'(j - 1);
        e  = n * Samp;
        eo = (e > PMax);
        if (eo) e = PMax;
        chk_s("sat", e, 1'b1, eo);
      end
    end
    drive(1'b1, Clear, 0, 0, 0);
    tick();
    drive(1'b0, Acc, 0, 0, 0);
    tick();
    tick();
    chk_s("sat_clear", 0, 1'b1, 1'b0);

    // 5. Wrap instance: exact bounds give no ovf, one past wraps with ovf.
    drive(1'b1, Load, 0, 0, 0);
    c_w = 40'sh80_0000_0000;
    tick();
    drive(1'b1, Sub, 1, 1, 0);
    tick();
    chk_w("wrap_min_exact", PMin, 1'b1, 1'b0);
    drive(1'b1, Load, 0, 0, 0);
    c_w = 40'sh7f_ffff_ffff;
    tick();
    chk_w("wrap_sub", PMax, 1'b1, 1'b1);
    chk_s("sat_load0", 0, 1'b1, 1'b0);
    drive(1'b1, Acc, 0, 0, 1);
    tick();
    chk_w("wrap_max_exact", PMax, 1'b1, 1'b0);
    chk_s("sat_sub", -1, 1'b1, 1'b0);
    drive(1'b0, Acc, 0, 0, 0);
    tick();
    chk_w("wrap_acc", PMin, 1'b1, 1'b1);
    chk_s("sat_load1", 0, 1'b1, 1'b0);
    tick();
    chk_s("sat_acc1", 1, 1'b1, 1'b0);

    // 6. Reset with samples in flight (ce low during reset: reset still wins).
    drive(1'b1, Load, 2, 2, 0);
    tick();
    drive(1'b1, Acc, 3, 3, 0);
    tick();
    chk_w("pre_rst", 4, 1'b1, 1'b0);
    rst = 1'b1;
    ce  = 1'b0;
    drive(1'b1, Acc, 4, 4, 0);
    tick();
    chk_s("mid_rst", 0, 1'b0, 1'b0);
    chk_w("mid_rst", 0, 1'b0, 1'b0);
    rst = 1'b0;
    ce  = 1'b1;
    drive(1'b0, Acc, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_s("after_rst", 0, 1'b0, 1'b0);
      chk_w("after_rst", 0, 1'b0, 1'b0);
    end
    drive(1'b1, Load, 2, 3, 4);
    tick();
    drive(1'b0, Acc, 0, 0, 0);
    tick();
    chk_w("first_after_rst", 10, 1'b1, 1'b0);
    chk_s("sat_not_yet", 0, 1'b0, 1'b0);
    tick();
    chk_s("first_after_rst", 10, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
